capture_thresh_loader: RTL and testbench
========================================

Name: capture_thresh_loader

Overview:
- Consumes the 32-bit user_data_out word of the capture0 load_thresh software register, in the user_clk domain.
- Decodes a threshold-load command from that word and writes one per-channel trigger threshold into an internal table.
- Streams the threshold for the channel currently on the channel-multiplexed capture pipeline to the downstream photon trigger comparator.
- Writes are committed only in the target channel's own time slot, so a threshold never changes part-way through that channel's sample.

Parameters:
- CH_W, 8, channel index width; N_CHAN = 2**CH_W table entries.
- TH_W, 16, threshold width, signed two's complement; TH_W <= 16.
- DEFAULT_THRESH, 16'sh8000, value written to every entry after reset (most negative, so the trigger is effectively disabled).
- TIMEOUT_CYC, 4096, WAIT_SLOT cycles allowed before a forced write.

Ports:
- user_clk  in  1  sole clock.
- user_rst_n  in  1  synchronous reset, active low.
- load_word  in  32  register word. Bit 31 is the load request. Bits [16+CH_W-1:16] are the channel. Bits [TH_W-1:0] are the threshold. All other bits are ignored.
- in_valid  in  1  capture stream sample valid.
- in_chan  in  CH_W  channel of the current sample.
- out_valid  out  1  in_valid delayed 1 cycle.
- out_chan  out  CH_W  in_chan delayed 1 cycle.
- thresh_out  out  TH_W  threshold for out_chan.
- busy  out  1  high in INIT, ARM, WAIT_SLOT and WRITE.
- load_done  out  1  high from the write until load bit 31 falls.
- timeout_err  out  1  sticky; set by a forced write, cleared by the next accepted load.
- load_count  out  16  number of completed writes; wraps modulo 2**16.

Behaviour:
- Reset (user_rst_n=0 at an edge) forces all outputs to 0 and the FSM to INIT. Bit 31 of the edge-detect register is also cleared.
- INIT state:
  - A CH_W-bit counter sweeps entries 0..N_CHAN-1, writing DEFAULT_THRESH, one entry per cycle.
  - Exit to IDLE after entry N_CHAN-1. INIT lasts exactly N_CHAN cycles.
  - thresh_out = DEFAULT_THRESH for any valid output during INIT.
- Load request detection:
  - Rising edge of load_word[31]: the bit is registered once, and req = bit31 & ~bit31_q.
  - An edge seen during INIT sets a pending flag, serviced on entry to IDLE.
  - Only one request can be pending; further edges while busy are dropped.
- IDLE: on req or pending, go to ARM.
- ARM (1 cycle):
  - Latch the channel and threshold from load_word.
  - Clear timeout_err and the timeout counter.
  - Go to WAIT_SLOT.
- WAIT_SLOT:
  - If in_valid and in_chan == latched channel, go to WRITE.
  - Otherwise, if the timeout counter == TIMEOUT_CYC-1, set timeout_err and go to WRITE.
  - Otherwise increment the counter.
- WRITE (1 cycle):
  - Write the table entry and increment load_count.
  - Set load_done; go to DONE.
- DONE: clear busy. Stay until load_word[31]=0, then clear load_done and go to IDLE.
- Read path:
  - Registered read, latency 1: thresh_out = table[in_chan] from the cycle before, together with out_valid/out_chan.
  - Same-cycle read and write of the same entry returns the OLD value (read-first). The new value appears from the next slot of that channel.
- Bit 31 held high: counts as one request only. Software must drop it before issuing another.
- A reset mid-operation abandons any load in flight and re-runs INIT; no partial write is allowed.

Decomposition:
- Package capture_thresh_pkg holds:
  - FSM state enum: INIT, IDLE, ARM, WAIT_SLOT, WRITE, DONE.
  - Load word field bit positions: LOAD_BIT=31, CHAN_LSB=16, TH_LSB=0.
- Sub-module thresh_table_ram: single-write, single-read, read-first, registered-read RAM of N_CHAN x TH_W, intended for distributed RAM.

Test Plan:
- Reset release, then in_valid on channels 0..255 -> busy=1 for exactly 256 cycles. thresh_out=16'sh8000 on every channel. load_count=0.
- load_word=32'h8005_0123 while the stream cycles 0..255 -> write occurs in the cycle in_chan=5. The next channel-5 sample gives thresh_out=16'h0123, and the other channels remain 16'h8000. load_count=1, load_done=1 until bit 31 is cleared.
- Same-slot read: the write to channel 5 coincides with a channel-5 read -> that output is still 16'h8000, and the following frame's output is 16'h0123.
- in_valid held 0 with load_word=32'h8010_FF00 -> the forced write happens TIMEOUT_CYC cycles after ARM. timeout_err=1, and table[16]=16'hFF00 on a later read. The next load clears timeout_err.
- Bit 31 rises during INIT -> the request is serviced after INIT, with exactly one write. Holding bit 31 high for 10000 cycles yields load_count +1 only.
- Reset asserted in WAIT_SLOT -> outputs are 0, INIT re-runs, the target entry reads DEFAULT_THRESH, and load_count=0.

Source files
------------

// File: rtl/capture_thresh_pkg.sv
// capture_thresh_pkg: shared types and load-word field positions for the
// capture0 threshold loader.
//   state_t   loader FSM states
//   LOAD_BIT  load request bit of the register word
//   CHAN_LSB  LSB of the channel field
//   TH_LSB    LSB of the threshold field
package capture_thresh_pkg;

   typedef enum logic [2:0] {
      INIT      = 3'd0,
      IDLE      = 3'd1,
      ARM       = 3'd2,
      WAIT_SLOT = 3'd3,
      WRITE     = 3'd4,
      DONE      = 3'd5
   } state_t;

   localparam int unsigned LOAD_BIT = 31;
   localparam int unsigned CHAN_LSB = 16;
   localparam int unsigned TH_LSB   = 0;

   // States in which the loader reports itself busy.
   function automatic logic is_busy(input state_t s);
      return (s == INIT) || (s == ARM) || (s == WAIT_SLOT) || (s == WRITE);
   endfunction

endpackage

// File: rtl/thresh_table_ram.sv
// thresh_table_ram: 2**AW x DW threshold table, one write port, one read port.
// Read is registered and read-first: a same-cycle write to the read address
// returns the old contents. rd_ovr substitutes ovr_data for the read result.
//   clk, rst_n        clock, synchronous active-low reset (read register only)
//   we, waddr, wdata  write port
//   raddr             read address
//   rd_ovr, ovr_data  read override
//   rdata             registered read data
module thresh_table_ram #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   input  logic          rd_ovr,
   input  logic [DW-1:0] ovr_data,
   output logic [DW-1:0] rdata
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];

   // Storage array; no reset so it maps onto distributed RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read register samples the pre-write contents.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (rd_ovr) begin
         rdata <= ovr_data;
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/capture_thresh_loader.sv
// capture_thresh_loader: decodes threshold-load commands from the capture0
// load_thresh register word and streams per-channel trigger thresholds to the
// photon trigger comparator, committing each write in its channel's own slot.
//   user_clk, user_rst_n  clock, synchronous active-low reset
//   load_word             register word: [31] request, [16+:CH_W] channel, [0+:TH_W] threshold
//   in_valid, in_chan     channel-multiplexed capture stream
//   out_valid, out_chan   stream delayed one cycle
//   thresh_out            threshold for out_chan
//   busy                  loader occupied (INIT/ARM/WAIT_SLOT/WRITE, one cycle behind the FSM)
//   load_done             write completed, held until the request bit drops
//   timeout_err           sticky: last write was forced by the slot timeout
//   load_count            completed writes, wrapping
module capture_thresh_loader
   import capture_thresh_pkg::*;
#(
   parameter int unsigned     CH_W           = 8,
   parameter int unsigned     TH_W           = 16,
   parameter logic [TH_W-1:0] DEFAULT_THRESH = TH_W'(16'h8000),
   parameter int unsigned     TIMEOUT_CYC    = 4096
) (
   input  logic            user_clk,
   input  logic            user_rst_n,
   input  logic [31:0]     load_word,
   input  logic            in_valid,
   input  logic [CH_W-1:0] in_chan,
   output logic            out_valid,
   output logic [CH_W-1:0] out_chan,
   output logic [TH_W-1:0] thresh_out,
   output logic            busy,
   output logic            load_done,
   output logic            timeout_err,
   output logic [15:0]     load_count
);

   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

   state_t            state_q, state_d;
   logic [CH_W-1:0]   init_cnt_q, init_cnt_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              pend_q, pend_d;
   logic              bit31_q;
   logic [CH_W-1:0]   chan_q, chan_d;
   logic [TH_W-1:0]   th_q, th_d;
   logic              done_d, tout_d;
   logic [15:0]       count_d;
   logic              req_c;
   logic              ram_we_c;
   logic [CH_W-1:0]   ram_waddr_c;
   logic [TH_W-1:0]   ram_wdata_c;
   logic              unused_ok;

   // Only the request, channel and threshold fields are decoded.
   assign unused_ok = ^load_word;

   assign req_c = load_word[LOAD_BIT] & ~bit31_q;

   // Next-state and write-port logic. The table entry is committed in the
   // WAIT_SLOT cycle that matches the slot (or times out); WRITE books it.
   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      to_cnt_d    = to_cnt_q;
      pend_d      = pend_q;
      chan_d      = chan_q;
      th_d        = th_q;
      done_d      = load_done;
      tout_d      = timeout_err;
      count_d     = load_count;
      ram_we_c    = 1'b0;
      ram_waddr_c = chan_q;
      ram_wdata_c = th_q;

      case (state_q)
         INIT: begin
            ram_we_c    = 1'b1;
            ram_waddr_c = init_cnt_q;
            ram_wdata_c = DEFAULT_THRESH;
            init_cnt_d  = init_cnt_q + 1'b1;
            if (req_c) begin
               pend_d = 1'b1;
            end
            if (init_cnt_q == {CH_W{1'b1}}) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (req_c || pend_q) begin
               pend_d  = 1'b0;
               state_d = ARM;
            end
         end
         ARM: begin
            chan_d   = load_word[CHAN_LSB +: CH_W];
            th_d     = load_word[TH_LSB +: TH_W];
            tout_d   = 1'b0;
            to_cnt_d = '0;
            state_d  = WAIT_SLOT;
         end
         WAIT_SLOT: begin
            if (in_valid && (in_chan == chan_q)) begin
               ram_we_c = 1'b1;
               state_d  = WRITE;
            end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
               ram_we_c = 1'b1;
               tout_d   = 1'b1;
               state_d  = WRITE;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         WRITE: begin
            count_d = load_count + 16'd1;
            done_d  = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            if (!load_word[LOAD_BIT]) begin
               done_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge user_clk) begin
      if (!user_rst_n) begin
         state_q     <= INIT;
         init_cnt_q  <= '0;
         to_cnt_q    <= '0;
         pend_q      <= 1'b0;
         bit31_q     <= 1'b0;
         chan_q      <= '0;
         th_q        <= '0;
         busy        <= 1'b0;
         load_done   <= 1'b0;
         timeout_err <= 1'b0;
         load_count  <= '0;
         out_valid   <= 1'b0;
         out_chan    <= '0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         to_cnt_q    <= to_cnt_d;
         pend_q      <= pend_d;
         bit31_q     <= load_word[LOAD_BIT];
         chan_q      <= chan_d;
         th_q        <= th_d;
         busy        <= is_busy(state_q);
         load_done   <= done_d;
         timeout_err <= tout_d;
         load_count  <= count_d;
         out_valid   <= in_valid;
         out_chan    <= in_chan;
      end
   end

   // Reset gates the write so an abandoned load never lands.
   thresh_table_ram #(
      .AW (CH_W),
      .DW (TH_W)
   ) u_table (
      .clk      (user_clk),
      .rst_n    (user_rst_n),
      .we       (ram_we_c & user_rst_n),
      .waddr    (ram_waddr_c),
      .wdata    (ram_wdata_c),
      .raddr    (in_chan),
      .rd_ovr   (state_q == INIT),
      .ovr_data (DEFAULT_THRESH),
      .rdata    (thresh_out)
   );

endmodule

// File: tb/tb_capture_thresh_loader.sv
// tb_capture_thresh_loader: self-checking bench for capture_thresh_loader.
// A timestamp-based reference model predicts every registered output each cycle;
// directed literal checks pin the key scenarios.
module tb_capture_thresh_loader;

   localparam int unsigned CH_W        = 8;
   localparam int unsigned TH_W        = 16;
   localparam int unsigned N_CHAN      = 256;
   localparam int unsigned TIMEOUT_CYC = 4096;
   localparam logic [15:0] DEF         = 16'h8000;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [31:0]     load_word;
   logic            in_valid;
   logic [CH_W-1:0] in_chan;
   logic            out_valid;
   logic [CH_W-1:0] out_chan;
   logic [TH_W-1:0] thresh_out;
   logic            busy;
   logic            load_done;
   logic            timeout_err;
   logic [15:0]     load_count;

   capture_thresh_loader #(
      .CH_W           (CH_W),
      .TH_W           (TH_W),
      .DEFAULT_THRESH (DEF),
      .TIMEOUT_CYC    (TIMEOUT_CYC)
   ) dut (
      .user_clk    (clk),
      .user_rst_n  (rst_n),
      .load_word   (load_word),
      .in_valid    (in_valid),
      .in_chan     (in_chan),
      .out_valid   (out_valid),
      .out_chan    (out_chan),
      .thresh_out  (thresh_out),
      .busy        (busy),
      .load_done   (load_done),
      .timeout_err (timeout_err),
      .load_count  (load_count)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (updated at each active edge) ----------
   int              cyc = 0;
   int              init_last = 0;
   int              arm = -1;
   int              commit = -1;
   bit              pend = 0;
   bit              prev31 = 0;
   bit              started = 0;
   logic [7:0]      mch;
   logic [15:0]     mth;
   logic [15:0]     mtab [N_CHAN];
   logic            e_valid, e_busy, e_done, e_tout, e_rst;
   logic [7:0]      e_chan;
   logic [15:0]     e_th, e_count;

   always @(posedge clk) begin
      bit req, in_init, live;
      cyc = cyc + 1;
      if (!rst_n) begin
         started = 1; e_rst = 1;
         e_valid = 0; e_chan = 0; e_th = 0; e_busy = 0;
         e_done = 0; e_tout = 0; e_count = 0;
         init_last = cyc + N_CHAN;
         arm = -1; commit = -1; pend = 0; prev31 = 0;
      end else begin
         e_rst   = 0;
         req     = load_word[31] && !prev31;
         prev31  = load_word[31];
         in_init = (cyc <= init_last);
         live    = (arm >= 0) && (commit < 0 || cyc <= commit + 1);
         e_valid = in_valid;
         e_chan  = in_chan;
         e_th    = in_init ? DEF : mtab[in_chan];
         e_busy  = in_init || live;
         if (in_init) begin
            if (req) pend = 1;
            if (cyc == init_last) foreach (mtab[i]) mtab[i] = DEF;
         end else if (arm < 0) begin
            if (req || pend) begin
               arm = cyc + 1; commit = -1; pend = 0;
            end
         end else if (cyc == arm) begin
            mch = load_word[23:16]; mth = load_word[15:0]; e_tout = 0;
         end else if (commit < 0) begin
            if (in_valid && in_chan == mch) begin
               mtab[mch] = mth; commit = cyc;
            end else if (cyc - arm == int'(TIMEOUT_CYC)) begin
               mtab[mch] = mth; commit = cyc; e_tout = 1;
            end
         end else if (cyc == commit + 1) begin
            e_count = e_count + 16'd1; e_done = 1;
         end else if (!load_word[31]) begin
            e_done = 0; arm = -1;
         end
      end
   end

   // ---------------- compare process ----------------------------------------
   typedef struct {
      string       name;
      logic [31:0] act;
      logic [31:0] exp;
   } lit_t;

   lit_t        lq[$];
   int          lq_rd = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [15:0] obs_th [N_CHAN];

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("out_valid", 32'(out_valid), 32'(e_valid));
         chk("out_chan", 32'(out_chan), 32'(e_chan));
         chk("busy", 32'(busy), 32'(e_busy));
         chk("load_done", 32'(load_done), 32'(e_done));
         chk("timeout_err", 32'(timeout_err), 32'(e_tout));
         chk("load_count", 32'(load_count), 32'(e_count));
         if (e_valid || e_rst) chk("thresh_out", 32'(thresh_out), 32'(e_th));
      end
      while (lq_rd < lq.size()) begin
         chk(lq[lq_rd].name, lq[lq_rd].act, lq[lq_rd].exp);
         lq_rd++;
      end
      if (out_valid === 1'b1) obs_th[out_chan] = thresh_out;
   end

   // ---------------- stimulus ------------------------------------------------
   int          smode = 1;
   logic [7:0]  pc;
   logic [15:0] pt;

   function automatic void lit(input string n, input logic [31:0] a, input logic [31:0] e);
      lq.push_back('{name: n, act: a, exp: e});
   endfunction

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         case (smode)
            0: in_valid = 1'b0;
            1: begin in_valid = 1'b1; in_chan = in_chan + 1'b1; end
            default: begin
               in_valid = ($urandom_range(0, 3) != 0);
               in_chan  = CH_W'($urandom_range(0, 15));
            end
         endcase
      end
   endtask

   task automatic wait_done(input int lim, output int k);
      k = 0;
      while (!load_done && k < lim) begin
         pc = out_chan; pt = thresh_out;
         step(1);
         k++;
      end
      if (!load_done) lit("wait_done_bound", 32'd0, 32'd1);
   endtask

   initial begin
      int          k, nbusy, bad, hold;
      logic [31:0] lw;
      rst_n = 1'b0; load_word = '0; in_valid = 1'b0; in_chan = '0;

      // Reset then INIT sweep with a continuous stream.
      step(3);
      rst_n = 1'b1;
      nbusy = 0;
      for (int i = 0; i < 300; i++) begin
         step(1);
         if (busy) nbusy++;
      end
      lit("init_busy_cycles", 32'(nbusy), 32'd256);
      lit("init_count", 32'(load_count), 32'd0);
      bad = 0;
      for (int i = 0; i < int'(N_CHAN); i++) if (obs_th[i] !== DEF) bad++;
      lit("init_default_all", 32'(bad), 32'd0);

      // Slot-aligned load of channel 5, read-first in the commit slot.
      load_word = 32'h8005_0123;
      wait_done(1000, k);
      lit("same_slot_chan", 32'(pc), 32'd5);
      lit("same_slot_old", 32'(pt), 32'(DEF));
      step(300);
      lit("ch5_new", 32'(obs_th[5]), 32'h0123);
      lit("ch6_default", 32'(obs_th[6]), 32'(DEF));
      lit("model_tab5", 32'(mtab[5]), 32'h0123);
      lit("count_one", 32'(load_count), 32'd1);
      lit("done_held", 32'(load_done), 32'd1);
      load_word = '0;
      step(3);
      lit("done_cleared", 32'(load_done), 32'd0);

      // Forced write by timeout with no stream.
      smode = 0; in_valid = 1'b0;
      step(2);
      load_word = 32'h8010_FF00;
      wait_done(5000, k);
      lit("timeout_latency", 32'(k), 32'(TIMEOUT_CYC + 3));
      lit("timeout_err_set", 32'(timeout_err), 32'd1);
      load_word = '0;
      smode = 1;
      step(300);
      lit("ch16_forced", 32'(obs_th[16]), 32'hFF00);
      lit("timeout_sticky", 32'(timeout_err), 32'd1);
      load_word = 32'h8020_1234;
      wait_done(1000, k);
      lit("timeout_err_clr", 32'(timeout_err), 32'd0);
      load_word = '0;
      step(3);

      // Request raised during INIT, then held high for a long time.
      rst_n = 1'b0;
      step(3);
      rst_n = 1'b1;
      step(10);
      load_word = 32'h8007_0777;
      step(10000);
      lit("held_count", 32'(load_count), 32'd1);
      lit("held_ch7", 32'(obs_th[7]), 32'h0777);
      load_word = '0;
      step(3);

      // Randomised loads against a random stream.
      smode = 2; hold = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            if (load_word[31]) begin
               load_word = '0;
            end else begin
               lw = $urandom;
               lw[31] = 1'b1;
               lw[23:16] = 8'($urandom_range(0, 15));
               load_word = lw;
            end
            hold = $urandom_range(1, 60);
         end else begin
            hold--;
         end
         step(1);
      end
      load_word = '0; smode = 1;
      step(300);

      // Reset while a load waits for its slot.
      smode = 0; in_valid = 1'b0;
      step(2);
      load_word = 32'h8030_ABCD;
      step(20);
      lit("wait_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      step(1);
      lit("rst_busy", 32'(busy), 32'd0);
      lit("rst_count", 32'(load_count), 32'd0);
      lit("rst_thresh", 32'(thresh_out), 32'd0);
      lit("rst_done", 32'(load_done), 32'd0);
      load_word = '0;
      step(1);
      rst_n = 1'b1; smode = 1;
      step(600);
      lit("abandoned_default", 32'(obs_th[8'h30]), 32'(DEF));
      lit("abandoned_count", 32'(load_count), 32'd0);

      step(3);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
